// File: rtl/delay_monitor.sv
// Watches an OR gate under test. For each change of a|b it measures how many
// clock edges pass until dut_out follows, then reports the result with a valid/ready handshake.
module delay_monitor #(
    parameter int CNT_W    = 8,
    parameter int MAX_WAIT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a,
    input  logic             b,
    input  logic             dut_out,
    input  logic             res_ready,
    output logic             res_valid,
    output logic [1:0]       res_code,
    output logic [CNT_W-1:0] res_delay,
    output logic [7:0]       drop_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        MEASURE,
        REPORT
    } state_t;

    localparam logic [1:0]       CODE_MATCH      = 2'b00;
    localparam logic [1:0]       CODE_SUPERSEDED = 2'b01;
    localparam logic [1:0]       CODE_TIMEOUT    = 2'b10;
    localparam logic [CNT_W-1:0] MAX_CNT         = CNT_W'(MAX_WAIT);

    state_t           state;
    logic             exp_q;
    logic             target;
    logic [CNT_W-1:0] cnt;
    logic             cur;
    logic             ev;
    logic [CNT_W-1:0] n;

    assign cur = a | b;
    assign ev  = (cur != exp_q);
    assign n   = cnt + CNT_W'(1);

    // exp_q follows a|b in every state, so changes seen while reporting are never re-detected later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            exp_q     <= 1'b0;
            target    <= 1'b0;
            cnt       <= '0;
            res_valid <= 1'b0;
            res_code  <= CODE_MATCH;
            res_delay <= '0;
            drop_cnt  <= 8'd0;
        end else begin
            exp_q <= cur;
            case (state)
                IDLE: begin
                    if (ev) begin
                        if (dut_out == cur) begin
                            state     <= REPORT;
                            res_valid <= 1'b1;
                            res_code  <= CODE_MATCH;
                            res_delay <= '0;
                        end else begin
                            target <= cur;
                            cnt    <= '0;
                            state  <= MEASURE;
                        end
                    end
                end
                MEASURE: begin
                    // Priority: a match wins over a superseding event, which wins over timeout.
                    if (dut_out == target) begin
                        state     <= REPORT;
                        res_valid <= 1'b1;
                        res_code  <= CODE_MATCH;
                        res_delay <= n;
                    end else if (ev) begin
                        state     <= REPORT;
                        res_valid <= 1'b1;
                        res_code  <= CODE_SUPERSEDED;
                        res_delay <= n;
                    end else if (n == MAX_CNT) begin
                        state     <= REPORT;
                        res_valid <= 1'b1;
                        res_code  <= CODE_TIMEOUT;
                        res_delay <= MAX_CNT;
                    end else begin
                        cnt <= n;
                    end
                end
                REPORT: begin
                    if (ev && (drop_cnt != 8'hFF)) begin
                        drop_cnt <= drop_cnt + 8'd1;
                    end
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    res_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_delay_monitor.sv
// Directed bench for delay_monitor: stimulus pushes expected results into a scoreboard
// queue and an independent monitor checks each presented result and its arrival edge.
module tb_delay_monitor;

    localparam int CNT_W    = 8;
    localparam int MAX_WAIT = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             a = 1'b0;
    logic             b = 1'b0;
    logic             dut_out = 1'b0;
    logic             res_ready = 1'b0;
    logic             res_valid;
    logic [1:0]       res_code;
    logic [CNT_W-1:0] res_delay;
    logic [7:0]       drop_cnt;

    typedef struct {
        logic [1:0] code;
        int         delay;
        int         at_edge;
    } exp_t;

    exp_t sbq[$];
    exp_t cur_exp;
    bit   seen = 1'b0;
    int   edge_no = 0;
    int   errors = 0;
    int   checks = 0;
    int   e0;

    delay_monitor #(.CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .dut_out   (dut_out),
        .res_ready (res_ready),
        .res_valid (res_valid),
        .res_code  (res_code),
        .res_delay (res_delay),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_no <= edge_no + 1;

    task automatic check_output(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_no);
        end
    endtask

    task automatic apply_stimulus(input logic na, input logic nb, input logic nd);
        a       = na;
        b       = nb;
        dut_out = nd;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_result(input logic [1:0] code, input int delay, input int at_edge);
        exp_t e;
        e.code    = code;
        e.delay   = delay;
        e.at_edge = at_edge;
        sbq.push_back(e);
    endtask

    // Monitor: pops one expectation per presented result, then checks it stays stable until handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (res_valid) begin
                if (!seen) begin
                    seen = 1'b1;
                    if (sbq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_result: got code %0d delay %0d, expected no result (edge %0d)",
                                 res_code, res_delay, edge_no);
                        cur_exp.code  = res_code;
                        cur_exp.delay = int'(res_delay);
                    end else begin
                        cur_exp = sbq.pop_front();
                        check_output("result_edge", edge_no, cur_exp.at_edge);
                        check_output("result_code", int'(res_code), int'(cur_exp.code));
                        check_output("result_delay", int'(res_delay), cur_exp.delay);
                    end
                end else begin
                    check_output("held_code", int'(res_code), int'(cur_exp.code));
                    check_output("held_delay", int'(res_delay), cur_exp.delay);
                end
            end else begin
                seen = 1'b0;
                if (sbq.size() > 0 && sbq[0].at_edge <= edge_no) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL missing_result: got none, expected code %0d delay %0d at edge %0d",
                             sbq[0].code, sbq[0].delay, sbq[0].at_edge);
                    void'(sbq.pop_front());
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #1 rst_n = 1'b0;
        tick(2);
        check_output("reset_valid", int'(res_valid), 0);
        check_output("reset_code", int'(res_code), 0);
        check_output("reset_delay", int'(res_delay), 0);
        check_output("reset_drop", int'(drop_cnt), 0);
        rst_n = 1'b1;
        tick(2);

        // Rising OR output, dut_out follows before the fourth edge.
        res_ready = 1'b1;
        apply_stimulus(1'b1, 1'b0, 1'b0);
        e0 = edge_no + 1;
        expect_result(2'b00, 4, e0 + 4);
        tick(4);
        dut_out = 1'b1;
        tick(3);
        apply_stimulus(1'b0, 1'b0, 1'b0);
        expect_result(2'b00, 0, edge_no + 1);
        tick(3);

        // Two-cycle pulse swallowed by the gate.
        apply_stimulus(1'b1, 1'b0, 1'b0);
        e0 = edge_no + 1;
        expect_result(2'b01, 2, e0 + 2);
        tick(2);
        a = 1'b0;
        tick(4);
        check_output("swallow_drop", int'(drop_cnt), 0);

        // Stuck output times out; the falling input then matches immediately.
        apply_stimulus(1'b0, 1'b1, 1'b0);
        e0 = edge_no + 1;
        expect_result(2'b10, MAX_WAIT, e0 + MAX_WAIT);
        tick(MAX_WAIT + 2);
        b = 1'b0;
        expect_result(2'b00, 0, edge_no + 1);
        tick(3);

        // Result held while the consumer stalls; three input changes are dropped.
        res_ready = 1'b0;
        apply_stimulus(1'b1, 1'b0, 1'b0);
        e0 = edge_no + 1;
        expect_result(2'b00, 1, e0 + 1);
        tick(1);
        dut_out = 1'b1;
        tick(1);
        a = 1'b0;
        tick(1);
        a = 1'b1;
        tick(1);
        a = 1'b0;
        tick(1);
        check_output("stall_valid", int'(res_valid), 1);
        check_output("stall_drop", int'(drop_cnt), 3);
        res_ready = 1'b1;
        dut_out   = 1'b0;
        tick(1);
        for (int i = 0; i < 4; i++) begin
            tick(1);
            check_output("no_spurious_valid", int'(res_valid), 0);
        end
        check_output("stall_drop_after", int'(drop_cnt), 3);

        // Match and superseding event on the same edge: match wins.
        apply_stimulus(1'b1, 1'b0, 1'b0);
        e0 = edge_no + 1;
        expect_result(2'b00, 2, e0 + 2);
        tick(2);
        apply_stimulus(1'b0, 1'b0, 1'b1);
        tick(3);
        dut_out = 1'b0;
        tick(2);

        // dut_out already at the new value on the event edge.
        dut_out = 1'b1;
        tick(1);
        a = 1'b1;
        expect_result(2'b00, 0, edge_no + 1);
        tick(3);
        apply_stimulus(1'b0, 1'b0, 1'b0);
        expect_result(2'b00, 0, edge_no + 1);
        tick(3);

        // Reset in the middle of a measurement with cnt at 5.
        apply_stimulus(1'b1, 1'b0, 1'b0);
        tick(6);
        #2 rst_n = 1'b0;
        #1;
        check_output("mid_measure_valid", int'(res_valid), 0);
        check_output("mid_measure_drop", int'(drop_cnt), 0);
        check_output("mid_measure_delay", int'(res_delay), 0);
        tick(2);

        // a held high across release gives an event on the first edge.
        res_ready = 1'b0;
        rst_n     = 1'b1;
        e0 = edge_no + 1;
        expect_result(2'b01, 3, e0 + 3);
        tick(3);
        a = 1'b0;
        tick(1);
        for (int i = 0; i < 300; i++) begin
            a = ~a;
            tick(1);
        end
        check_output("drop_saturate", int'(drop_cnt), 255);
        check_output("drop_valid", int'(res_valid), 1);

        // Reset while a result is pending discards it.
        #2 rst_n = 1'b0;
        #1;
        check_output("mid_report_valid", int'(res_valid), 0);
        check_output("mid_report_code", int'(res_code), 0);
        check_output("mid_report_delay", int'(res_delay), 0);
        check_output("mid_report_drop", int'(drop_cnt), 0);
        apply_stimulus(1'b0, 1'b0, 1'b0);
        tick(2);
        rst_n     = 1'b1;
        res_ready = 1'b1;
        tick(2);

        apply_stimulus(1'b1, 1'b0, 1'b1);
        expect_result(2'b00, 0, edge_no + 1);
        tick(3);
        apply_stimulus(1'b0, 1'b0, 1'b0);
        expect_result(2'b00, 0, edge_no + 1);
        tick(4);

        check_output("scoreboard_empty", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/delay_monitor.md
DELAY_MONITOR -- requirements
Module: delay_monitor

Interface
REQ-001 SHALL provide parameter CNT_W, default 8, meaning width of the delay counter and the res_delay field.
REQ-002 SHALL provide parameter MAX_WAIT, default 16, meaning the timeout in clock edges after an event (1 <= MAX_WAIT <= 2^CNT_W-1).
REQ-003 SHALL provide port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL provide port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL provide ports a, b  input  1 each  stimulus applied to the OR gate under observation.
REQ-006 SHALL provide port dut_out  input  1  delayed OR output under observation.
REQ-007 SHALL provide port res_valid  output  1  result available.
REQ-008 SHALL provide port res_ready  input  1  consumer accepts the result.
REQ-009 SHALL provide port res_code  output  2  result code: 00 MATCH, 01 SUPERSEDED, 10 TIMEOUT; 11 never driven.
REQ-010 SHALL provide port res_delay  output  CNT_W  measured delay in clock edges.
REQ-011 SHALL provide port drop_cnt  output  8  count of events not measured.

Function
REQ-012 SHALL register exp_q <= a|b on every edge, in all states.
REQ-013 SHALL define an event as an edge at which (a|b) != exp_q; target = a|b sampled at that edge.
REQ-014 SHALL implement an FSM with states IDLE, MEASURE and REPORT.
REQ-015 In IDLE, on an event with dut_out == target at the same edge, SHALL go to REPORT with MATCH and delay 0.
REQ-016 In IDLE, on an event with dut_out != target, SHALL latch target, set cnt = 0 and go to MEASURE.
REQ-017 In MEASURE, each edge SHALL compute n = cnt+1; if dut_out == target, SHALL go to REPORT with MATCH and delay n.
REQ-018 In MEASURE, with no match and an event, SHALL go to REPORT with SUPERSEDED and delay n; the superseding event is not measured and does not increment drop_cnt.
REQ-019 In MEASURE, with no match, no event and n == MAX_WAIT, SHALL go to REPORT with TIMEOUT and delay MAX_WAIT.
REQ-020 If several MEASURE conditions hold on one edge, priority SHALL be MATCH, then SUPERSEDED, then TIMEOUT.
REQ-021 Otherwise MEASURE SHALL set cnt = n and stay.
REQ-022 In REPORT, res_valid SHALL be 1, and res_code/res_delay SHALL be held stable until handshake.
REQ-023 Handshake SHALL be the edge with res_valid && res_ready; REPORT SHALL then go to IDLE (1-cycle minimum IDLE).
REQ-024 res_valid SHALL be 0 in IDLE and MEASURE.
REQ-025 res_code/res_delay SHALL be don't-care when res_valid = 0; the bench SHALL not check them then.
REQ-026 Every event at an edge in REPORT, including the handshake edge, SHALL increment drop_cnt, saturating at 255.
REQ-027 res_ready SHALL be ignored outside REPORT.
REQ-028 Because exp_q tracks continuously, input changes during REPORT SHALL never be re-detected on return to IDLE.

Reset
REQ-029 rst_n low SHALL immediately force: state IDLE, res_valid 0, res_code 00, res_delay 0, drop_cnt 0, cnt 0, exp_q 0.
REQ-030 Reset asserted mid-MEASURE or mid-REPORT SHALL discard the pending result.
REQ-031 After release, if a|b = 1, the first edge SHALL see an event (exp_q = 0).

Verification
REQ-032 Scenario: a 0->1 before edge E0, dut_out rises before edge E0+4, res_ready = 1 -> res_valid at E0+4, code 00, delay 4, handshake next edge.
REQ-033 Scenario: a high for exactly 2 cycles, dut_out stays 0 (inertial swallow) -> SUPERSEDED, delay 2, drop_cnt 0.
REQ-034 Scenario: b 0->1, dut_out stuck 0 -> TIMEOUT, delay 16 at E0+16.
REQ-035 Scenario: res_ready held 0, a toggles 3 times during REPORT -> result unchanged, drop_cnt = 3; after ready, IDLE with no spurious event.
REQ-036 Scenario: a 0->1 with dut_out already 1 at the same edge -> MATCH, delay 0; on a separate run, a match and an event on the same MEASURE edge -> MATCH.
REQ-037 Scenario: rst_n pulsed low mid-MEASURE (cnt = 5) -> outputs at reset values asynchronously, no result reported; 300 dropped events -> drop_cnt = 255.
